// File: rtl/config_sequencer.sv
// Configuration bus sequencer: buffers host words in a small FIFO and issues one
// config bus write per cycle, expanding broadcast words into one write per tile.
module config_sequencer #(
  parameter int DEPTH     = 4,
  parameter int NUM_TILES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] LAST_TILE = 16'(NUM_TILES - 1);

  typedef enum logic {IDLE, BCAST} state_t;

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] sub_q, sub_d;
  logic [31:0] bdata_q, bdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        wr_q, wr_d;
  logic [15:0] ww_q, ww_d;

  logic        empty, full, push, pop;
  logic [31:0] head_addr, head_data;
  logic        head_term, head_bcast;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign head_addr  = addr_mem[rd_ptr_q[AW-1:0]];
  assign head_data  = data_mem[rd_ptr_q[AW-1:0]];
  assign head_term  = (head_addr == 32'hFFFF_FFFF);
  assign head_bcast = (head_addr[15:0] == 16'hFFFF) && !head_term;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= in_addr;
      data_mem[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    bdata_d = bdata_q;
    addr_d  = 32'd0;
    data_d  = 32'd0;
    done_d  = done_q;
    wr_d    = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_term) begin
            done_d = 1'b1;
          end else if (head_bcast) begin
            sub_d   = head_addr[31:16];
            bdata_d = head_data;
            addr_d  = {head_addr[31:16], 16'd0};
            data_d  = head_data;
            cnt_d   = 16'd1;
            done_d  = 1'b0;
            wr_d    = 1'b1;
            if (NUM_TILES != 1) state_d = BCAST;
          end else begin
            addr_d = head_addr;
            data_d = head_data;
            done_d = 1'b0;
            wr_d   = 1'b1;
          end
        end
      end
      BCAST: begin
        addr_d = {sub_q, cnt_q};
        data_d = bdata_q;
        wr_d   = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == LAST_TILE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    ww_d     = (wr_d && ww_q != 16'hFFFF) ? ww_q + 16'd1 : ww_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      sub_q    <= 16'd0;
      bdata_q  <= 32'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      ww_q     <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      bdata_q  <= bdata_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      wr_q     <= wr_d;
      ww_q     <= ww_d;
    end
  end

  assign config_addr   = addr_q;
  assign config_data   = data_q;
  assign done          = done_q;
  assign words_written = ww_q;
  assign busy          = !empty || (state_q != IDLE) || wr_q;

endmodule

// File: doc/config_sequencer.md
# config_sequencer

Drives the array-wide configuration bus (`config_addr`/`config_data`) seen by every tile. It accepts configuration words from the bitstream host over a valid/ready stream and buffers them in a small FIFO. It then issues exactly one bus write per cycle, expanding broadcast words into one write per tile. It sits between the host interface and the tile array; tiles decode `config_addr[15:0]` as tile id and `config_addr[31:16]` as sub-block select (4/5 = connect boxes, 6 = switch box, 7 = logic block).

## Interface
- `DEPTH`, 4: input FIFO depth in words; power of two, ≥2.
- `NUM_TILES`, 16: tile ids covered by a broadcast (0 … NUM_TILES-1); range 1…65535.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_addr`  in  32  host config address.
- `in_data`  in  32  host config data.
- `config_addr`  out  32  registered bus address; 0 when idle.
- `config_data`  out  32  registered bus data; 0 when idle.
- `busy`  out  1  FIFO non-empty, or FSM not IDLE, or bus currently non-idle.
- `done`  out  1  sticky; terminator word processed.
- `words_written`  out  16  count of bus write cycles, saturating at 0xFFFF.

## Operation
- Idle bus value: addr 0, data 0. Sub-block 0 matches no tile decoder, so an idle bus is a no-op.
- Push: on an edge with `in_valid && in_ready`, the word enters the FIFO tail.
  - `in_ready` derives from the pre-edge full flag only. A pop in the same cycle does not free a slot for that cycle's push.
- Word classes, checked at FIFO head:
  - Terminator: `in_addr == 32'hFFFF_FFFF`. Popped with no bus write; sets `done`.
  - Broadcast: `addr[15:0] == 16'hFFFF`, not a terminator. Produces NUM_TILES writes.
  - Normal: everything else. Produces one write.
- FSM states: IDLE, BCAST.
  - IDLE, FIFO empty: bus loads idle value.
  - IDLE, head normal: pop; bus loads {addr, data}; stay IDLE.
  - IDLE, head terminator: pop; bus loads idle; `done` ← 1.
  - IDLE, head broadcast: pop; latch addr[31:16] and data; bus loads {addr[31:16], 16'd0}, data; tile counter ← 1; if NUM_TILES == 1 stay IDLE, else → BCAST.
  - BCAST: bus loads {sub, counter}, data; counter++. On counter == NUM_TILES-1 → IDLE. No FIFO pop while in BCAST.
- `done` clears when a non-terminator word is popped.
- `words_written` increments on every edge that loads a non-idle bus value. It stops at 0xFFFF.
- Reset (async assert, any time, including mid-broadcast):
  - FIFO emptied, FSM → IDLE, counter 0.
  - `config_addr`/`config_data` 0, `done` 0, `words_written` 0, `busy` 0, `in_ready` 1.
  - A broadcast in progress is abandoned.

## Timing
- Latency: word pushed at edge E0 with an empty FIFO and FSM IDLE is popped at E1. The bus holds it E1→E2, and tiles capture it at E2.
- Throughput: one bus write per cycle sustained. Back-to-back writes need no idle gap between them.
- Broadcast: exactly NUM_TILES consecutive bus cycles with tile ids ascending 0…NUM_TILES-1. The next head word issues on the edge after the last broadcast write.
- Terminator: costs one idle bus cycle.
- `busy` falls the cycle after the last write leaves the bus.
- FIFO full boundary: with DEPTH words held, `in_ready` is 0 and asserted words are held by the host. `in_ready` returns to 1 the cycle after a pop.
- Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

## Test plan
- Reset then a single normal word (addr 0x0004_0003, data 0xA5) → bus shows 0x0004_0003/0xA5 for exactly one cycle, one cycle after accept; `words_written` = 1; then bus returns to 0.
- 6 normal words streamed with DEPTH=4 and `in_valid` held high → `in_ready` never drops (1/cycle drain); 6 consecutive bus cycles in order; count 6.
- Broadcast addr 0x0006_FFFF, data 0x3C, NUM_TILES=16 → 16 cycles with addr 0x0006_0000…0x0006_000F, data 0x3C; count 16. Words pushed meanwhile fill the FIFO and `in_ready` = 0 once it holds 4.
- Terminator after 2 normal words → 2 writes, one idle cycle, then `done` = 1 sticky; a subsequent normal word clears `done`.
- Assert `rst` low at the 5th cycle of a broadcast → outputs are 0 immediately (asynchronously); after release, the FIFO is empty, `in_ready` = 1, and no remaining broadcast writes appear.
- Preload `words_written` near saturation via 65 540 writes → value is held at 0xFFFF.
